wb_arbiter_rr: RTL and testbench

- Parametrised N-master to 1-slave Wishbone arbiter for the simulation SoC; replaces the fixed two-master (ibus/dbus) grant logic.
- Round-robin grant among NUM_MASTERS masters, held for the whole bus cycle (CYC).
- Adds a bus watchdog: a strobe left unacknowledged for TIMEOUT cycles is aborted, and ERR is returned to the granted master.

---
 rtl/wb_arbiter_rr.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: N-master to 1-slave Wishbone arbiter with round-robin grant
// held for the whole bus cycle, plus a watchdog that aborts a stalled strobe.
//
// Handshake: a master owns the bus while it holds CYC and its index is the
// grant. A transfer is offered while the slave-side CYC and STB are both
// high, and it completes on the first cycle the slave raises ACK or ERR.
// Masters must hold address, data and controls stable until then. A watchdog
// abort completes the transfer with ERR on the arbiter's own authority.
module wb_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int ADR_WIDTH   = 30,
    parameter int DAT_WIDTH   = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*ADR_WIDTH-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DAT_WIDTH-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*DAT_WIDTH/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]             m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]             m_bte_i,
    output logic [DAT_WIDTH-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic [ADR_WIDTH-1:0]                 s_adr_o,
    output logic [DAT_WIDTH-1:0]                 s_dat_o,
    output logic [DAT_WIDTH/8-1:0]               s_sel_o,
    output logic [2:0]                           s_cti_o,
    output logic [1:0]                           s_bte_o,
    input  logic [DAT_WIDTH-1:0]                 s_dat_i,
    input  logic                                 s_ack_i,
    input  logic                                 s_err_i,
    output logic [$clog2(NUM_MASTERS)-1:0]       grant_o,
    output logic                                 timeout_o
);

    localparam int GW = $clog2(NUM_MASTERS);
    localparam int SW = DAT_WIDTH / 8;

    logic [GW-1:0] grant_q;
    logic [GW-1:0] grant_d;
    logic [GW-1:0] cand;
    int            idx;
    logic          found;
    logic          abort_q;

    // Round-robin search: keep the owner while it holds CYC, otherwise pick
    // the first requester after the owner, wrapping from N-1 back to 0.
    always_comb begin
        grant_d = grant_q;
        cand    = '0;
        idx     = 0;
        found   = 1'b0;
        if (!m_cyc_i[grant_q]) begin
            for (int k = 1; k < NUM_MASTERS; k++) begin
                idx = int'(grant_q) + k;
                if (idx >= NUM_MASTERS) begin
                    idx = idx - NUM_MASTERS;
                end
                cand = GW'(idx);
                if (!found && m_cyc_i[cand]) begin
                    grant_d = cand;
                    found   = 1'b1;
                end
            end
        end
    end

    // Grant register; abort does not influence arbitration.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            grant_q <= '0;
        end else begin
            grant_q <= grant_d;
        end
    end

    // Slave side follows the granted master; CYC/STB are killed during abort.
    always_comb begin
        s_adr_o = m_adr_i[int'(grant_q)*ADR_WIDTH +: ADR_WIDTH];
        s_dat_o = m_dat_i[int'(grant_q)*DAT_WIDTH +: DAT_WIDTH];
        s_sel_o = m_sel_i[int'(grant_q)*SW +: SW];
        s_cti_o = m_cti_i[int'(grant_q)*3 +: 3];
        s_bte_o = m_bte_i[int'(grant_q)*2 +: 2];
        s_we_o  = m_we_i[grant_q];
        s_cyc_o = m_cyc_i[grant_q] & ~abort_q;
        s_stb_o = m_stb_i[grant_q] & ~abort_q;
    end

    // Responses go only to the granted master; abort turns into ERR and
    // swallows any late ACK. ACK and ERR together are passed on unchanged.
    always_comb begin
        m_dat_o          = s_dat_i;
        m_ack_o          = '0;
        m_err_o          = '0;
        m_ack_o[grant_q] = s_ack_i & ~abort_q;
        m_err_o[grant_q] = (s_err_i & ~abort_q) | abort_q;
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT + 1);

            logic          stall;
            logic [CW-1:0] wd_q;
            logic [CW-1:0] wd_d;
            logic          abort_d;

            assign stall = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;

            // Count consecutive stalled cycles; the TIMEOUT-th one fires abort.
            // Abort forces STB low, so the flag drops again after one cycle.
            always_comb begin
                wd_d    = '0;
                abort_d = 1'b0;
                if (stall) begin
                    if (wd_q == CW'(TIMEOUT - 1)) begin
                        abort_d = 1'b1;
                    end else begin
                        wd_d = wd_q + CW'(1);
                    end
                end
            end

            // Watchdog counter and abort flag registers.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    wd_q    <= '0;
                    abort_q <= 1'b0;
                end else begin
                    wd_q    <= wd_d;
                    abort_q <= abort_d;
                end
            end
        end else begin : g_no_wd
            assign abort_q = 1'b0;
        end
    endgenerate

    assign grant_o   = grant_q;
    assign timeout_o = abort_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb_wb_arbiter_rr: directed bench for the round-robin Wishbone arbiter.
// Main instance: 4 masters, TIMEOUT=16. Second instance: 2 masters, no watchdog.
module tb_wb_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;
    localparam int ZN = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- main DUT signals ----------------
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat;
    logic [N*SW-1:0]   m_sel;
    logic [N*3-1:0]    m_cti;
    logic [N*2-1:0]    m_bte;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic [DW-1:0]     s_dat;
    logic              s_ack, s_err;
    logic [1:0]        grant_o;
    logic              timeout_o;

    wb_arbiter_rr #(.NUM_MASTERS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
        .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // ---------------- watchdog-less DUT signals ----------------
    logic [ZN-1:0]     z_cyc, z_stb, z_we;
    logic [ZN*AW-1:0]  z_adr;
    logic [ZN*DW-1:0]  z_dat;
    logic [ZN*SW-1:0]  z_sel;
    logic [ZN*3-1:0]   z_cti;
    logic [ZN*2-1:0]   z_bte;
    logic [DW-1:0]     z_dat_o;
    logic [ZN-1:0]     z_ack_o, z_err_o;
    logic              z_s_cyc, z_s_stb, z_s_we;
    logic [AW-1:0]     z_s_adr;
    logic [DW-1:0]     z_s_dat;
    logic [SW-1:0]     z_s_sel;
    logic [2:0]        z_s_cti;
    logic [1:0]        z_s_bte;
    logic              z_grant;
    logic              z_timeout;

    wb_arbiter_rr #(.NUM_MASTERS(ZN), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(0)) dut_z (
        .sys_clk(clk), .sys_rst(rst),
        .m_cyc_i(z_cyc), .m_stb_i(z_stb), .m_we_i(z_we), .m_adr_i(z_adr),
        .m_dat_i(z_dat), .m_sel_i(z_sel), .m_cti_i(z_cti), .m_bte_i(z_bte),
        .m_dat_o(z_dat_o), .m_ack_o(z_ack_o), .m_err_o(z_err_o),
        .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_adr_o(z_s_adr),
        .s_dat_o(z_s_dat), .s_sel_o(z_s_sel), .s_cti_o(z_s_cti), .s_bte_o(z_s_bte),
        .s_dat_i(32'h0), .s_ack_i(1'b0), .s_err_i(1'b0),
        .grant_o(z_grant), .timeout_o(z_timeout)
    );

    // ---------------- scoreboard ----------------
    int checks;
    int failures;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [AW-1:0] adr);
        return {2'b00, adr} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] wdata_of(input int m);
        return 32'hC0DE_0000 | 32'(m);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [AW-1:0] adr, input logic [2:0] cti);
        m_cyc[m] = cyc;
        m_stb[m] = stb;
        m_we[m]  = we;
        m_adr[m*AW +: AW] = adr;
        m_dat[m*DW +: DW] = wdata_of(m);
        m_sel[m*SW +: SW] = SW'(m + 1);
        m_cti[m*3 +: 3]   = cti;
        m_bte[m*2 +: 2]   = 2'(m);
    endtask

    // Single read by an already-granted master; slave acks after one wait cycle.
    task automatic do_read(input int m, input logic [AW-1:0] adr);
        m_stb[m] = 1'b1;
        m_we[m]  = 1'b0;
        m_adr[m*AW +: AW] = adr;
        exp_q.push_back(slave_data(adr));
        s_ack = 1'b0;
        settle();
        chk("adr_mux", 32'(s_adr_o), 32'(adr));
        chk("ack_wait", 32'(m_ack_o), 32'h0);
        tick();
        s_ack = 1'b1;
        s_dat = slave_data(s_adr_o);
        settle();
        chk("read_ack", 32'(m_ack_o), 32'(1) << m);
        chk("read_data", m_dat_o, exp_q.pop_front());
        tick();
        s_ack = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int zbad;
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
        m_sel = '0; m_cti = '0; m_bte = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
        z_cyc = '0; z_stb = '0; z_we = '0; z_adr = '0; z_dat = '0;
        z_sel = '0; z_cti = '0; z_bte = '0;

        // reset state
        #2;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_err", 32'(m_err_o), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // grant wait: master 0 holds the bus for three reads
        drive_m(0, 1'b1, 1'b0, 1'b0, 30'h100, 3'b000);
        do_read(0, 30'h100);
        drive_m(2, 1'b1, 1'b1, 1'b0, 30'h200, 3'b000);
        drive_m(3, 1'b1, 1'b1, 1'b0, 30'h300, 3'b000);
        m_stb[1] = 1'b1;   // stray STB without CYC must be ignored
        settle();
        chk("hold_grant0_a", 32'(grant_o), 32'h0);
        do_read(0, 30'h104);
        chk("hold_grant0_b", 32'(grant_o), 32'h0);
        do_read(0, 30'h108);
        chk("hold_grant0_c", 32'(grant_o), 32'h0);
        m_cyc[0] = 1'b0;
        settle();
        chk("drop_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("drop_grant_still0", 32'(grant_o), 32'h0);
        tick();
        chk("grant_to_2", 32'(grant_o), 32'h2);
        m_stb[1] = 1'b0;
        do_read(2, 30'h204);
        m_cyc[2] = 1'b0;
        tick();
        chk("grant_to_3", 32'(grant_o), 32'h3);

        // write-field muxing from master 3
        m_we[3]  = 1'b1;
        m_stb[3] = 1'b1;
        settle();
        chk("s_we", 32'(s_we_o), 32'h1);
        chk("s_dat", s_dat_o, wdata_of(3));
        chk("s_sel", 32'(s_sel_o), 32'h4);
        chk("s_bte", 32'(s_bte_o), 32'h3);
        s_ack = 1'b1;
        settle();
        chk("write_ack", 32'(m_ack_o), 32'h8);
        tick();
        s_ack = 1'b0;
        m_we[3]  = 1'b0;
        m_stb[3] = 1'b0;
        do_read(3, 30'h30C);

        // wrap-around 3 -> 0 -> 1
        m_cyc[0] = 1'b1;
        m_cyc[1] = 1'b1;
        tick();
        chk("wrap_hold3", 32'(grant_o), 32'h3);
        m_cyc[3] = 1'b0;
        tick();
        chk("wrap_to_0", 32'(grant_o), 32'h0);
        m_cyc[0] = 1'b0;
        tick();
        chk("wrap_to_1", 32'(grant_o), 32'h1);
        m_cyc[1] = 1'b0;

        // idle hold at grant 2
        m_cyc[2] = 1'b1;
        tick();
        chk("idle_grant2", 32'(grant_o), 32'h2);
        m_cyc[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_hold", 32'(grant_o), 32'h2);
            chk("idle_s_cyc", 32'(s_cyc_o), 32'h0);
        end

        // watchdog abort on master 1
        drive_m(1, 1'b1, 1'b1, 1'b0, 30'h150, 3'b000);
        tick();
        chk("wd_grant1", 32'(grant_o), 32'h1);
        chk("wd_s_stb", 32'(s_stb_o), 32'h1);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("wd_no_err", 32'(m_err_o), 32'h0);
            chk("wd_no_timeout", 32'(timeout_o), 32'h0);
        end
        tick();
        s_ack = 1'b1;   // late ack in the abort cycle
        settle();
        chk("abort_err", 32'(m_err_o), 32'h2);
        chk("abort_no_ack", 32'(m_ack_o), 32'h0);
        chk("abort_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("abort_s_stb", 32'(s_stb_o), 32'h0);
        chk("abort_timeout", 32'(timeout_o), 32'h1);
        s_ack = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        tick();
        chk("abort_one_cycle", 32'(timeout_o), 32'h0);
        chk("abort_err_clear", 32'(m_err_o), 32'h0);

        // ack in the last permitted cycle: no abort, counter restarts
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        settle();
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("lim_no_err", 32'(m_err_o), 32'h0);
        end
        s_ack = 1'b1;
        settle();
        chk("lim_ack", 32'(m_ack_o), 32'h2);
        chk("lim_ack_no_err", 32'(m_err_o), 32'h0);
        tick();
        s_ack = 1'b0;
        settle();
        chk("lim_no_timeout", 32'(timeout_o), 32'h0);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("lim_restart_no_err", 32'(m_err_o), 32'h0);
        end
        tick();
        chk("lim_restart_abort", 32'(m_err_o), 32'h2);
        chk("lim_restart_timeout", 32'(timeout_o), 32'h1);
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        tick();

        // simultaneous ack and err are both forwarded
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        s_ack = 1'b1;
        s_err = 1'b1;
        settle();
        chk("both_ack", 32'(m_ack_o), 32'h2);
        chk("both_err", 32'(m_err_o), 32'h2);
        tick();
        s_ack = 1'b0;
        s_err = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        tick();

        // async reset during a master-2 incrementing burst
        drive_m(2, 1'b1, 1'b1, 1'b0, 30'h400, 3'b010);
        tick();
        chk("burst_grant2", 32'(grant_o), 32'h2);
        chk("burst_cti", 32'(s_cti_o), 32'h2);
        s_ack = 1'b1;
        settle();
        chk("burst_ack", 32'(m_ack_o), 32'h4);
        tick();
        tick();
        s_ack = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tick();
        end
        chk("burst_abort", 32'(timeout_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_grant", 32'(grant_o), 32'h0);
        chk("async_rst_timeout", 32'(timeout_o), 32'h0);
        chk("async_rst_err", 32'(m_err_o), 32'h0);
        chk("async_rst_s_cyc", 32'(s_cyc_o), 32'h0);
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        m_cti    = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_grant", 32'(grant_o), 32'h0);

        // no-watchdog build: a long stall never produces ERR
        z_cyc[0] = 1'b1;
        z_stb[0] = 1'b1;
        zbad = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (z_err_o !== '0 || z_timeout !== 1'b0) zbad++;
        end
        chk("z_no_err", 32'(zbad), 32'h0);
        chk("z_s_cyc", 32'(z_s_cyc), 32'h1);
        z_cyc[1] = 1'b1;
        z_cyc[0] = 1'b0;
        z_stb[0] = 1'b0;
        tick();
        chk("z_grant1", 32'(z_grant), 32'h1);
        z_cyc[1] = 1'b0;
        z_cyc[0] = 1'b1;
        tick();
        chk("z_wrap0", 32'(z_grant), 32'h0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
